axil_button_poll_ctrl: RTL and testbench

- AXI4-Lite read-only master that periodically sweeps the button slave's register bank, starting at C_BASE_ADDR.
- Keeps a shadow copy of all registers, raises a one-cycle change pulse and a sticky interrupt when any bit changes, and flags bus errors.
- Sits between the button AXI-Lite slave and the security-system alarm logic, so the alarm logic never drives AXI itself.

---
 rtl/axil_button_poll_ctrl.sv | 159 +++++++++++++++
 tb/tb_axil_button_poll_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_button_poll_ctrl.sv
// rtl/axil_button_poll_ctrl.sv - AXI4-Lite read-only poller that shadows the button slave register bank
// Optional feature macro: AXIL_BTN_DEBOUNCE_EN (commit a register only after two identical sweeps)
module axil_button_poll_ctrl #(
    parameter int                              C_M_AXI_ADDR_WIDTH = 32,
    parameter int                              C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   C_BASE_ADDR        = '0,
    parameter int                              NUM_REGS           = 4,
    parameter int                              POLL_PERIOD        = 100000
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    input  logic                               enable,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [2:0]                         m_axi_arprot,
    output logic                               m_axi_arvalid,
    input  logic                               m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      m_axi_rdata,
    input  logic [1:0]                         m_axi_rresp,
    input  logic                               m_axi_rvalid,
    output logic                               m_axi_rready,
    output logic [NUM_REGS*32-1:0]             btn_state,
    output logic                               btn_changed,
    output logic                               irq,
    input  logic                               irq_ack,
    output logic                               bus_err,
    output logic                               overrun,
    output logic                               busy
);

    localparam int          SW     = NUM_REGS * 32;
    localparam logic [31:0] RELOAD = 32'(POLL_PERIOD - 1);
    localparam logic [3:0]  LAST   = 4'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, UPDATE} state_t;

    state_t          state;
    logic [31:0]     timer;
    logic            tick;
    logic [3:0]      idx;
    logic [8:0]      lane;
    logic [SW-1:0]   snap;
    logic [SW-1:0]   commit_v;
`ifdef AXIL_BTN_DEBOUNCE_EN
    logic [SW-1:0]   prev_snap;
`endif

    assign tick         = (timer == 32'd0);
    assign lane         = {idx, 5'b00000};
    assign m_axi_arprot = 3'b000;
    assign busy         = (state != IDLE);

    function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] addr_of(input logic [3:0] i);
        return C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({i, 2'b00});
    endfunction

    // Free-running sweep timer; ticks at zero and reloads, independent of enable and FSM state
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            timer <= RELOAD;
        end else if (tick) begin
            timer <= RELOAD;
        end else begin
            timer <= timer - 32'd1;
        end
    end

    // Value that UPDATE would commit: the whole snapshot, or only registers stable across two sweeps
    always_comb begin
        commit_v = btn_state;
`ifdef AXIL_BTN_DEBOUNCE_EN
        for (int k = 0; k < NUM_REGS; k++) begin
            if (snap[k*32 +: 32] == prev_snap[k*32 +: 32]) begin
                commit_v[k*32 +: 32] = snap[k*32 +: 32];
            end
        end
`else
        commit_v = snap;
`endif
    end

    // Sweep FSM: one outstanding read at a time, shadow/irq/error bookkeeping with registered outputs
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            idx           <= 4'd0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            snap          <= '0;
            btn_state     <= '0;
            btn_changed   <= 1'b0;
            irq           <= 1'b0;
            bus_err       <= 1'b0;
            overrun       <= 1'b0;
`ifdef AXIL_BTN_DEBOUNCE_EN
            prev_snap     <= '0;
`endif
        end else begin
            btn_changed <= 1'b0;
            if (irq_ack) begin
                irq <= 1'b0;
            end
            // A tick during a sweep is dropped but remembered
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick && enable) begin
                        idx           <= 4'd0;
                        m_axi_araddr  <= addr_of(4'd0);
                        m_axi_arvalid <= 1'b1;
                        state         <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        if (m_axi_rresp == 2'b00) begin
                            snap[lane +: 32] <= m_axi_rdata;
                        end else begin
                            // Failed read: keep what we already believe about this register
                            snap[lane +: 32] <= btn_state[lane +: 32];
                            bus_err          <= 1'b1;
                        end
                        if (idx == LAST) begin
                            state <= UPDATE;
                        end else begin
                            idx           <= idx + 4'd1;
                            m_axi_araddr  <= addr_of(idx + 4'd1);
                            m_axi_arvalid <= 1'b1;
                            state         <= ADDR;
                        end
                    end
                end
                UPDATE: begin
                    if (commit_v != btn_state) begin
                        btn_state   <= commit_v;
                        btn_changed <= 1'b1;
                        irq         <= 1'b1;
                    end
`ifdef AXIL_BTN_DEBOUNCE_EN
                    prev_snap <= snap;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_button_poll_ctrl.sv
// tb/tb_axil_button_poll_ctrl.sv - self-checking bench for axil_button_poll_ctrl
module tb_axil_button_poll_ctrl;

    localparam int NR = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [31:0]  araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] btn_state;
    logic         btn_changed;
    logic         irq;
    logic         irq_ack;
    logic         bus_err;
    logic         overrun;
    logic         busy;

    axil_button_poll_ctrl #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .C_BASE_ADDR        (32'h0000_0000),
        .NUM_REGS           (NR),
        .POLL_PERIOD        (64)
    ) dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .enable        (enable),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .btn_state     (btn_state),
        .btn_changed   (btn_changed),
        .irq           (irq),
        .irq_ack       (irq_ack),
        .bus_err       (bus_err),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Slave register contents and per-register behaviour
    logic [31:0] slave_regs [NR];
    logic [NR-1:0] err_mask;
    int ar_stall [NR];
    int r_stall  [NR];
    logic [31:0] ar_q [$];

    // Event counters sampled on the falling edge
    int chg_cnt   = 0;
    int sweep_cnt = 0;
    logic busy_q  = 1'b0;
    always @(negedge clk) begin
        if (btn_changed) chg_cnt++;
        if (busy && !busy_q) sweep_cnt++;
        busy_q = busy;
    end

    // Behavioural AXI-Lite slave, stepped once per cycle just after the rising edge
    int s_st, s_cnt, s_ri;
    logic [31:0] s_addr;

    task automatic start_ar();
        s_addr = araddr;
        ar_q.push_back(araddr);
        s_ri  = int'(araddr[3:2]);
        s_cnt = ar_stall[s_ri];
        if (s_cnt == 0) arready = 1'b1;
        s_st = 1;
    endtask

    task automatic drive_r();
        rdata  = slave_regs[s_ri];
        rresp  = err_mask[s_ri] ? 2'b10 : 2'b00;
        rvalid = 1'b1;
    endtask

    initial begin
        s_st = 0; s_cnt = 0; s_ri = 0; s_addr = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                s_st = 0; arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
            end else begin
                case (s_st)
                    0: if (arvalid) start_ar();
                    1: begin
                        if (arready) begin
                            arready = 1'b0;
                            chk("one_outstanding", arvalid, 1'b0);
                            s_cnt = r_stall[s_ri];
                            if (s_cnt == 0) drive_r();
                            s_st = 2;
                        end else begin
                            chk("ar_hold_valid", arvalid, 1'b1);
                            chk("ar_hold_addr", araddr, s_addr);
                            s_cnt--;
                            if (s_cnt == 0) arready = 1'b1;
                        end
                    end
                    default: begin
                        if (rvalid) begin
                            rvalid = 1'b0; rresp = 2'b00;
                            s_st = 0;
                            if (arvalid) start_ar();
                        end else begin
                            chk("no_ar_in_data", arvalid, 1'b0);
                            s_cnt--;
                            if (s_cnt == 0) drive_r();
                        end
                    end
                endcase
            end
        end
    end

    task automatic set_slave(input logic [127:0] regs, input logic [NR-1:0] err);
        for (int k = 0; k < NR; k++) slave_regs[k] = regs[k*32 +: 32];
        err_mask = err;
    endtask

    task automatic set_stalls(input int a, input int r);
        for (int k = 0; k < NR; k++) begin ar_stall[k] = a; r_stall[k] = r; end
    endtask

    // Waits for one complete sweep; returns in the low phase right after busy drops
    task automatic wait_sweep();
        int n;
        n = 0;
        while (!busy && n < 200) begin @(negedge clk); n++; end
        if (!busy) chk("sweep_start_timeout", busy, 1'b1);
        n = 0;
        while (busy && n < 2000) begin @(negedge clk); n++; end
        if (busy) chk("sweep_end_timeout", busy, 1'b0);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_arvalid"}, arvalid, 1'b0);
        chk({tag, "_rready"}, rready, 1'b0);
        chk({tag, "_araddr"}, araddr, 32'h0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_state"}, btn_state, 128'h0);
        chk({tag, "_changed"}, btn_changed, 1'b0);
        chk({tag, "_irq"}, irq, 1'b0);
        chk({tag, "_bus_err"}, bus_err, 1'b0);
        chk({tag, "_overrun"}, overrun, 1'b0);
        chk({tag, "_arprot"}, arprot, 3'b000);
    endtask

    typedef struct {
        logic [127:0] regs;
        logic [3:0]   err;
        int           ars2;
        int           rs2;
        logic [127:0] exp_state;
        int           exp_chg;
        logic         exp_berr;
    } vec_t;

    vec_t tv [5];

    // Reference model state for the randomized phase
    logic [31:0] m_st   [NR];
    logic [31:0] m_prev [NR];
    logic        m_irq, m_berr;

    initial begin
        logic [31:0]  snapv [NR];
        logic [31:0]  nv;
        logic [127:0] exp_pk;
        logic         changed, anyerr;
        int           s0, n;

        tv[0] = '{128'h00000004_00000003_00000002_00000001, 4'b0000, 0, 0,
                  128'h00000004_00000003_00000002_00000001, 1, 1'b0};
        tv[1] = '{128'h00000004_00000003_00000002_00000001, 4'b0000, 0, 0,
                  128'h00000004_00000003_00000002_00000001, 0, 1'b0};
        tv[2] = '{128'h00000040_00000030_00000020_00000010, 4'b0010, 0, 0,
                  128'h00000040_00000030_00000002_00000010, 1, 1'b1};
        tv[3] = '{128'h0000000a_00000009_00000008_00000007, 4'b0000, 5, 7,
                  128'h0000000a_00000009_00000008_00000007, 1, 1'b1};
        tv[4] = '{128'hffffffff_ffffffff_ffffffff_ffffffff, 4'b1111, 0, 0,
                  128'h0000000a_00000009_00000008_00000007, 0, 1'b1};

        rst_n = 1'b0; enable = 1'b0; irq_ack = 1'b0;
        set_slave('0, '0);
        set_stalls(0, 0);
        repeat (4) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1; enable = 1'b1;

`ifndef AXIL_BTN_DEBOUNCE_EN
        for (int i = 0; i < 5; i++) begin
            set_slave(tv[i].regs, tv[i].err);
            set_stalls(0, 0);
            ar_stall[2] = tv[i].ars2;
            r_stall[2]  = tv[i].rs2;
            chg_cnt = 0;
            ar_q.delete();
            wait_sweep();
            chk($sformatf("vec%0d_state", i), btn_state, tv[i].exp_state);
            chk($sformatf("vec%0d_changed", i), chg_cnt, tv[i].exp_chg);
            chk($sformatf("vec%0d_irq", i), irq, 1'b1);
            chk($sformatf("vec%0d_bus_err", i), bus_err, tv[i].exp_berr);
            if (i == 0) begin
                chk("addr_count", ar_q.size(), 4);
                for (int k = 0; k < 4 && k < ar_q.size(); k++)
                    chk($sformatf("addr%0d", k), ar_q[k], 32'(4 * k));
            end
        end
`else
        begin
            logic [31:0] seq   [5];
            logic [31:0] exp0  [5];
            int          expc  [5];
            seq  = '{32'd5, 32'd5, 32'd7, 32'd8, 32'd8};
            exp0 = '{32'd0, 32'd5, 32'd5, 32'd5, 32'd8};
            expc = '{0, 1, 0, 0, 1};
            for (int i = 0; i < 5; i++) begin
                set_slave({96'h0, seq[i]}, '0);
                chg_cnt = 0;
                wait_sweep();
                chk($sformatf("deb%0d_state", i), btn_state, {96'h0, exp0[i]});
                chk($sformatf("deb%0d_changed", i), chg_cnt, expc[i]);
            end
            chk("deb_irq", irq, 1'b1);
        end
`endif

        // irq stays until acknowledged
        irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
        chk("irq_acked", irq, 1'b0);

        // Ack held across the change cycle: set wins
        set_slave(128'h00000111_00000222_00000333_00000444, '0);
`ifdef AXIL_BTN_DEBOUNCE_EN
        wait_sweep();
`endif
        irq_ack = 1'b1;
        chg_cnt = 0;
        wait_sweep();
        chk("ack_same_cycle_irq", irq, 1'b1);
        chk("ack_same_cycle_chg", chg_cnt, 1);
        irq_ack = 1'b0;

        // enable dropped mid-sweep: sweep finishes, no new ones
        n = 0;
        while (!busy && n < 200) begin @(negedge clk); n++; end
        chk("en_sweep_seen", busy, 1'b1);
        enable = 1'b0;
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        chk("en_sweep_completes", busy, 1'b0);
        s0 = sweep_cnt;
        repeat (150) @(negedge clk);
        chk("en_no_new_sweep", sweep_cnt, s0);
        enable = 1'b1;

        // Slow slave: sweep outlasts the poll period
        chk("overrun_pre", overrun, 1'b0);
        set_stalls(10, 10);
        wait_sweep();
        chk("overrun_set", overrun, 1'b1);

        // Reset in the middle of a data phase
        n = 0;
        while (!rready && n < 400) begin @(negedge clk); n++; end
        chk("mid_data_reached", rready, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        set_stalls(0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Randomized sweeps against a rule-level model, starting from the clean reset state
        for (int k = 0; k < NR; k++) begin m_st[k] = '0; m_prev[k] = '0; end
        m_irq = 1'b0; m_berr = 1'b0;
        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < NR; k++) begin
                if ($urandom_range(0, 2) != 0) slave_regs[k] = $urandom & 32'h3;
                err_mask[k] = ($urandom_range(0, 7) == 0);
                ar_stall[k] = $urandom_range(0, 3);
                r_stall[k]  = $urandom_range(0, 3);
            end
            changed = 1'b0; anyerr = 1'b0;
            for (int k = 0; k < NR; k++) begin
                snapv[k] = err_mask[k] ? m_st[k] : slave_regs[k];
                anyerr |= err_mask[k];
`ifdef AXIL_BTN_DEBOUNCE_EN
                nv = (snapv[k] == m_prev[k]) ? snapv[k] : m_st[k];
                m_prev[k] = snapv[k];
`else
                nv = snapv[k];
`endif
                if (nv != m_st[k]) changed = 1'b1;
                m_st[k] = nv;
            end
            if (changed) m_irq = 1'b1;
            if (anyerr) m_berr = 1'b1;
            for (int k = 0; k < NR; k++) exp_pk[k*32 +: 32] = m_st[k];
            chg_cnt = 0;
            wait_sweep();
            chk($sformatf("rnd%0d_state", it), btn_state, exp_pk);
            chk($sformatf("rnd%0d_changed", it), chg_cnt, int'(changed));
            chk($sformatf("rnd%0d_irq", it), irq, m_irq);
            chk($sformatf("rnd%0d_bus_err", it), bus_err, m_berr);
            chk($sformatf("rnd%0d_overrun", it), overrun, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
                m_irq = 1'b0;
                chk($sformatf("rnd%0d_ack", it), irq, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
